// File: rtl/qar_gpio_pkg.sv
// Shared definitions for the qar GPIO peripheral: register offsets, bus FSM
// states and the register-select decode used by the top level.
package qar_gpio_pkg;

    localparam logic [31:0] GPIO_IN   = 32'h0000_0000;
    localparam logic [31:0] GPIO_OUT  = 32'h0000_0004;
    localparam logic [31:0] GPIO_DIR  = 32'h0000_0008;
    localparam logic [31:0] GPIO_EN   = 32'h0000_000C;
    localparam logic [31:0] GPIO_RISE = 32'h0000_0010;
    localparam logic [31:0] GPIO_FALL = 32'h0000_0014;
    localparam logic [31:0] GPIO_STAT = 32'h0000_0018;
    localparam logic [31:0] GPIO_SET  = 32'h0000_001C;
    localparam logic [31:0] GPIO_CLR  = 32'h0000_0020;
    localparam logic [31:0] GPIO_TGL  = 32'h0000_0024;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_t;

    typedef enum logic [3:0] {
        SEL_IN   = 4'd0,
        SEL_OUT  = 4'd1,
        SEL_DIR  = 4'd2,
        SEL_EN   = 4'd3,
        SEL_RISE = 4'd4,
        SEL_FALL = 4'd5,
        SEL_STAT = 4'd6,
        SEL_SET  = 4'd7,
        SEL_CLR  = 4'd8,
        SEL_TGL  = 4'd9,
        SEL_NONE = 4'd10
    } reg_sel_t;

    function automatic reg_sel_t decode_offset(input logic [31:0] off);
        reg_sel_t sel;
        case (off)
            GPIO_IN:   sel = SEL_IN;
            GPIO_OUT:  sel = SEL_OUT;
            GPIO_DIR:  sel = SEL_DIR;
            GPIO_EN:   sel = SEL_EN;
            GPIO_RISE: sel = SEL_RISE;
            GPIO_FALL: sel = SEL_FALL;
            GPIO_STAT: sel = SEL_STAT;
            GPIO_SET:  sel = SEL_SET;
            GPIO_CLR:  sel = SEL_CLR;
            GPIO_TGL:  sel = SEL_TGL;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/qar_gpio_sync.sv
// Pad input synchroniser: SYNC_STAGES flop chain per pin plus a one-cycle
// delayed copy of the last stage for edge detection.
module qar_gpio_sync
    import qar_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync_val,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain and previous-value flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
            prev_r <= {WIDTH{1'b0}};
        end else begin
            stage_r[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            prev_r <= stage_r[SYNC_STAGES-1];
        end
    end

    assign sync_val = stage_r[SYNC_STAGES-1];
    assign rise_raw = stage_r[SYNC_STAGES-1] & ~prev_r;
    assign fall_raw = ~stage_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/qar_gpio_periph.sv
// Memory-mapped GPIO responder on the qar_core data bus: output, direction and
// edge-interrupt registers, synchronised pad inputs and a level interrupt.
module qar_gpio_periph
    import qar_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    input  logic [WIDTH-1:0]      gpio_in,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_dir,
    output logic                  gpio_irq
);

    bus_state_t       state_r, state_next_s;
    logic             accept_s;
    logic             mem_ready_r;
    logic [31:0]      mem_rdata_r;
    logic             irq_r;

    logic [WIDTH-1:0] out_r, dir_r, en_r, rise_r, fall_r, stat_r;
    logic [WIDTH-1:0] out_next_s, dir_next_s, en_next_s, rise_next_s, fall_next_s, stat_next_s;
    logic [WIDTH-1:0] stat_clr_s, rd_w_s, wdata_s;
    logic [WIDTH-1:0] sync_s, rise_raw_s, fall_raw_s;
    logic [31:0]      off_s, rd_s;
    reg_sel_t         sel_s;
    logic             unused_s;

    qar_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (gpio_in),
        .sync_val (sync_s),
        .rise_raw (rise_raw_s),
        .fall_raw (fall_raw_s)
    );

    assign wdata_s  = mem_wdata[WIDTH-1:0];
    assign unused_s = ^{mem_addr[1:0], mem_wdata};

    // Word-aligned offset decode, zero-extended for comparison with the map
    always_comb begin
        off_s = 32'd0;
        off_s[ADDR_WIDTH-1:2] = mem_addr[ADDR_WIDTH-1:2];
        sel_s = decode_offset(off_s);
    end

    // Bus FSM next state: a request is only taken from IDLE, so RESP always
    // returns to IDLE and back-to-back transfers are at most one per 2 cycles
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            BUS_IDLE: begin
                if (mem_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = BUS_RESP;
                end else begin
                    state_next_s = BUS_IDLE;
                end
            end
            BUS_RESP: state_next_s = BUS_IDLE;
            default:  state_next_s = BUS_IDLE;
        endcase
    end

    // Register-file write decode and status set/clear (a new edge beats W1C)
    always_comb begin
        out_next_s  = out_r;
        dir_next_s  = dir_r;
        en_next_s   = en_r;
        rise_next_s = rise_r;
        fall_next_s = fall_r;
        stat_clr_s  = {WIDTH{1'b0}};
        if (accept_s && mem_we) begin
            case (sel_s)
                SEL_OUT:  out_next_s  = wdata_s;
                SEL_DIR:  dir_next_s  = wdata_s;
                SEL_EN:   en_next_s   = wdata_s;
                SEL_RISE: rise_next_s = wdata_s;
                SEL_FALL: fall_next_s = wdata_s;
                SEL_STAT: stat_clr_s  = wdata_s;
                SEL_SET:  out_next_s  = out_r | wdata_s;
                SEL_CLR:  out_next_s  = out_r & ~wdata_s;
                SEL_TGL:  out_next_s  = out_r ^ wdata_s;
                default:  out_next_s  = out_r;
            endcase
        end else begin
            stat_clr_s = {WIDTH{1'b0}};
        end
        stat_next_s = (stat_r & ~stat_clr_s) | (rise_raw_s & rise_r) | (fall_raw_s & fall_r);
    end

    // Read mux; write-only and unmapped offsets return zero
    always_comb begin
        rd_w_s = {WIDTH{1'b0}};
        rd_s   = 32'd0;
        if (accept_s && !mem_we) begin
            case (sel_s)
                SEL_IN:   rd_w_s = sync_s;
                SEL_OUT:  rd_w_s = out_r;
                SEL_DIR:  rd_w_s = dir_r;
                SEL_EN:   rd_w_s = en_r;
                SEL_RISE: rd_w_s = rise_r;
                SEL_FALL: rd_w_s = fall_r;
                SEL_STAT: rd_w_s = stat_r;
                default:  rd_w_s = {WIDTH{1'b0}};
            endcase
        end else begin
            rd_w_s = {WIDTH{1'b0}};
        end
        rd_s[WIDTH-1:0] = rd_w_s;
    end

    // State, register file, bus response and interrupt registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= BUS_IDLE;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'd0;
            out_r       <= {WIDTH{1'b0}};
            dir_r       <= {WIDTH{1'b0}};
            en_r        <= {WIDTH{1'b0}};
            rise_r      <= {WIDTH{1'b0}};
            fall_r      <= {WIDTH{1'b0}};
            stat_r      <= {WIDTH{1'b0}};
            irq_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mem_ready_r <= accept_s;
            mem_rdata_r <= rd_s;
            out_r       <= out_next_s;
            dir_r       <= dir_next_s;
            en_r        <= en_next_s;
            rise_r      <= rise_next_s;
            fall_r      <= fall_next_s;
            stat_r      <= stat_next_s;
            irq_r       <= |(stat_r & en_r);
        end
    end

    assign mem_ready = mem_ready_r;
    assign mem_rdata = mem_rdata_r;
    assign gpio_out  = out_r;
    assign gpio_dir  = dir_r;
    assign gpio_irq  = irq_r;

endmodule
